// File: rtl/pc_stack.sv
// pc_stack: LIFO return-address stack with a circular top pointer.
// Storage is a DEPTH x W register array; pushes and pops only move the
// pointer, so entries are never shifted.
// Optional build macro PC_STACK_WRAP_EN: when defined, a PUSH on a full
// stack overwrites the oldest entry instead of being dropped.
module pc_stack #(
   parameter int W     = 11,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               ctl,
   input  logic [W-1:0]             din,
   input  logic                     err_clr,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic                     ovf,
   output logic                     unf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_PUSH = 2'b01;
   localparam logic [1:0] OP_POP  = 2'b10;
   localparam logic [1:0] OP_REPL = 2'b11;

`ifdef PC_STACK_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] top_reg, top_next;
   logic [CW-1:0] count_reg, count_next;
   logic          ovf_reg, ovf_next;
   logic          unf_reg, unf_next;

   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] ptr_inc;
   logic [AW-1:0] ptr_dec;
   logic          set_ovf;
   logic          set_unf;

   assign ptr_inc = top_reg + AW'(1);
   assign ptr_dec = top_reg - AW'(1);

   assign empty = (count_reg == '0);
   assign full  = (count_reg == CW'(DEPTH));
   assign count = count_reg;
   assign ovf   = ovf_reg;
   assign unf   = unf_reg;
   assign dout  = empty ? '0 : mem[top_reg];

   // Decode the operation into pointer/count updates and an array write.
   // The slot just above the top is also the oldest entry when full, so a
   // wrapping push needs no special addressing.
   always_comb begin
      top_next   = top_reg;
      count_next = count_reg;
      wr_en      = 1'b0;
      wr_addr    = top_reg;
      set_ovf    = 1'b0;
      set_unf    = 1'b0;
      case (ctl)
         OP_PUSH: begin
            if (full) begin
               set_ovf = 1'b1;
            end
            if (!full || WRAP_EN) begin
               top_next = ptr_inc;
               wr_en    = 1'b1;
               wr_addr  = ptr_inc;
               if (!full) begin
                  count_next = count_reg + CW'(1);
               end
            end
         end
         OP_POP: begin
            if (empty) begin
               set_unf = 1'b1;
            end else begin
               top_next   = ptr_dec;
               count_next = count_reg - CW'(1);
            end
         end
         OP_REPL: begin
            if (empty) begin
               // Nothing to replace: behave as a push and flag the underflow.
               set_unf    = 1'b1;
               top_next   = ptr_inc;
               count_next = count_reg + CW'(1);
               wr_en      = 1'b1;
               wr_addr    = ptr_inc;
            end else begin
               wr_en   = 1'b1;
               wr_addr = top_reg;
            end
         end
         default: begin
            // OP_NOP: hold everything.
         end
      endcase
   end

   // Sticky error flags: a new error in the same cycle wins over err_clr.
   always_comb begin
      ovf_next = set_ovf | (ovf_reg & ~err_clr);
      unf_next = set_unf | (unf_reg & ~err_clr);
   end

   // Pointer, occupancy and flags; cleared immediately by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         top_reg   <= '0;
         count_reg <= '0;
         ovf_reg   <= 1'b0;
         unf_reg   <= 1'b0;
      end else begin
         top_reg   <= top_next;
         count_reg <= count_next;
         ovf_reg   <= ovf_next;
         unf_reg   <= unf_next;
      end
   end

   // Entry array: not reset, its contents are hidden while the stack is empty.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem[wr_addr] <= din;
      end
   end

endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed + random checks of pc_stack in two configurations
// (W=11/DEPTH=8 and W=16/DEPTH=4) driven by the same operation stream and
// compared against a list-based reference model.
module tb_pc_stack;

`ifdef PC_STACK_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   localparam logic [1:0] NOP  = 2'b00;
   localparam logic [1:0] PUSH = 2'b01;
   localparam logic [1:0] POP  = 2'b10;
   localparam logic [1:0] REPL = 2'b11;

   logic        clk;
   logic        rst;
   logic [1:0]  ctl;
   logic [15:0] din;
   logic        err_clr;

   logic [10:0] dout8;
   logic [3:0]  count8;
   logic        empty8, full8, ovf8, unf8;
   logic [15:0] dout4;
   logic [2:0]  count4;
   logic        empty4, full4, ovf4, unf4;

   int checks = 0;
   int errors = 0;

   pc_stack #(.W(11), .DEPTH(8)) u8 (
      .clk(clk), .rst(rst), .ctl(ctl), .din(din[10:0]), .err_clr(err_clr),
      .dout(dout8), .count(count8), .empty(empty8), .full(full8),
      .ovf(ovf8), .unf(unf8)
   );

   pc_stack #(.W(16), .DEPTH(4)) u4 (
      .clk(clk), .rst(rst), .ctl(ctl), .din(din), .err_clr(err_clr),
      .dout(dout4), .count(count4), .empty(empty4), .full(full4),
      .ovf(ovf4), .unf(unf4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: element 0 is the bottom of the stack, mc[i] entries.
   int          dep [2] = '{8, 4};
   logic [15:0] msk [2] = '{16'h07FF, 16'hFFFF};
   logic [15:0] ms  [2][8];
   int          mc  [2];
   bit          mo  [2];
   bit          mu  [2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mc[i] = 0;
         mo[i] = 1'b0;
         mu[i] = 1'b0;
      end
   endtask

   task automatic model_step(input logic [1:0] c, input logic [15:0] d, input bit ec);
      for (int i = 0; i < 2; i++) begin
         bit eo;
         bit eu;
         logic [15:0] v;
         eo = 1'b0;
         eu = 1'b0;
         v  = d & msk[i];
         case (c)
            PUSH: begin
               if (mc[i] < dep[i]) begin
                  ms[i][mc[i]] = v;
                  mc[i]++;
               end else begin
                  eo = 1'b1;
                  if (WRAP) begin
                     for (int k = 0; k < dep[i] - 1; k++) ms[i][k] = ms[i][k+1];
                     ms[i][dep[i]-1] = v;
                  end
               end
            end
            POP: begin
               if (mc[i] == 0) eu = 1'b1;
               else mc[i]--;
            end
            REPL: begin
               if (mc[i] == 0) begin
                  eu = 1'b1;
                  ms[i][0] = v;
                  mc[i] = 1;
               end else begin
                  ms[i][mc[i]-1] = v;
               end
            end
            default: ;
         endcase
         mo[i] = eo | (mo[i] & ~ec);
         mu[i] = eu | (mu[i] & ~ec);
      end
   endtask

   function automatic logic [15:0] mtop(input int i);
      return (mc[i] == 0) ? 16'h0 : ms[i][mc[i]-1];
   endfunction

   task automatic check_all();
      check("dout8",  32'(dout8),  32'(mtop(0)));
      check("count8", 32'(count8), 32'(mc[0]));
      check("empty8", 32'(empty8), 32'(mc[0] == 0));
      check("full8",  32'(full8),  32'(mc[0] == 8));
      check("ovf8",   32'(ovf8),   32'(mo[0]));
      check("unf8",   32'(unf8),   32'(mu[0]));
      check("dout4",  32'(dout4),  32'(mtop(1)));
      check("count4", 32'(count4), 32'(mc[1]));
      check("empty4", 32'(empty4), 32'(mc[1] == 0));
      check("full4",  32'(full4),  32'(mc[1] == 4));
      check("ovf4",   32'(ovf4),   32'(mo[1]));
      check("unf4",   32'(unf4),   32'(mu[1]));
   endtask

   // One operation: drive, clock, advance the model, check.
   task automatic step(input logic [1:0] c, input logic [15:0] d, input bit ec);
      ctl     = c;
      din     = d;
      err_clr = ec;
      @(posedge clk);
      #1;
      model_step(c, d, ec);
      ctl     = NOP;
      err_clr = 1'b0;
      check_all();
      $display("op=%0d din=%h clr=%0d | d8=%h c8=%0d d4=%h c4=%0d", c, d, ec, dout8, count8, dout4, count4);
   endtask

   // Synchronous-looking full reset pulse placed mid-cycle.
   task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      #2;
      rst = 1'b0;
   endtask

   initial begin
      logic [15:0] vals [20];
      logic [15:0] exp_v;

      rst     = 1'b1;
      ctl     = NOP;
      din     = '0;
      err_clr = 1'b0;
      model_reset();
      #12;
      check_all();
      check("rst_dout8",  32'(dout8),  32'h0);
      check("rst_empty8", 32'(empty8), 32'h1);
      rst = 1'b0;

      // Fill and drain with known values.
      for (int k = 1; k <= 8; k++) step(PUSH, 16'h100 + 16'(k), 1'b0);
      check("r030_full",  32'(full8),  32'h1);
      check("r030_count", 32'(count8), 32'h8);
      check("r030_top",   32'(dout8),  32'h108);
      for (int k = 1; k <= 8; k++) begin
         step(POP, 16'h0, 1'b0);
         check("r030_pop", 32'(dout8), (k < 8) ? 32'(32'h108 - k) : 32'h0);
      end
      check("r030_empty", 32'(empty8), 32'h1);

      // Underflow and sticky clearing.
      step(POP, 16'h0, 1'b0);
      check("r031_unf", 32'(unf8), 32'h1);
      step(NOP, 16'h0, 1'b1);
      check("r031_clr", 32'(unf8), 32'h0);
      step(POP, 16'h0, 1'b1);
      check("r031_setwins", 32'(unf8), 32'h1);
      step(NOP, 16'h0, 1'b1);

      // Overflow on a full stack.
      for (int k = 1; k <= 8; k++) step(PUSH, 16'h100 + 16'(k), 1'b0);
      step(PUSH, 16'h1FF, 1'b0);
      check("r032_ovf", 32'(ovf8), 32'h1);
      check("r032_top", 32'(dout8), WRAP ? 32'h1FF : 32'h108);
      for (int k = 0; k < 8; k++) step(POP, 16'h0, 1'b0);
      step(NOP, 16'h0, 1'b1);

      // Replace semantics.
      step(PUSH, 16'h055, 1'b0);
      step(PUSH, 16'h066, 1'b0);
      step(REPL, 16'h077, 1'b0);
      check("r033_count", 32'(count8), 32'h2);
      check("r033_top",   32'(dout8),  32'h077);
      step(POP, 16'h0, 1'b0);
      check("r033_pop", 32'(dout8), 32'h055);
      step(POP, 16'h0, 1'b0);
      step(REPL, 16'h0AA, 1'b0);
      check("r033_rcount", 32'(count8), 32'h1);
      check("r033_rtop",   32'(dout8),  32'h0AA);
      check("r033_unf",    32'(unf8),   32'h1);

      // Asynchronous reset between edges.
      step(NOP, 16'h0, 1'b1);
      for (int k = 0; k < 3; k++) step(PUSH, 16'h0123 + 16'(k), 1'b0);
      rst = 1'b1;
      #1;
      model_reset();
      check("r034_count", 32'(count8), 32'h0);
      check("r034_empty", 32'(empty8), 32'h1);
      check("r034_dout",  32'(dout8),  32'h0);
      check_all();
      #1;
      rst = 1'b0;
      step(POP, 16'h0, 1'b0);
      check("r034_unf", 32'(unf8), 32'h1);

      // Long run of pushes then pops; the 4-deep instance wraps its pointer.
      do_reset();
      for (int k = 0; k < 20; k++) begin
         vals[k] = 16'($urandom);
         step(PUSH, vals[k], 1'b0);
      end
      for (int k = 0; k < 20; k++) begin
         step(POP, 16'h0, 1'b0);
         if (k < 3) begin
            exp_v = WRAP ? vals[18-k] : vals[2-k];
            check("r035_lifo4", 32'(dout4), 32'(exp_v));
         end
      end

      // Random operations, with one asynchronous reset in the middle.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         if (n == 200) do_reset();
         step(2'($urandom_range(0, 3)), 16'($urandom), ($urandom_range(0, 15) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter W, default 11: entry width in bits (return-address width).
REQ-002 Parameter DEPTH, default 8: number of entries; power of two and at least 2.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 ctl  input  2  operation: 00 NOP, 01 PUSH, 10 POP, 11 REPLACE (pop and push in one cycle).
REQ-006 din  input  W  value written by PUSH and REPLACE.
REQ-007 err_clr  input  1  clears the sticky ovf and unf flags.
REQ-008 dout  output  W  current top-of-stack entry; 0 when the stack is empty.
REQ-009 count  output  clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
REQ-010 empty  output  1  high when count==0.
REQ-011 full  output  1  high when count==DEPTH.
REQ-012 ovf  output  1  sticky overflow flag: a PUSH was issued while full.
REQ-013 unf  output  1  sticky underflow flag: a POP or REPLACE was issued while empty.

Function
REQ-014 Storage shall be a DEPTH x W register array addressed by a circular top pointer; no entry shifting.
REQ-015 dout, count, empty and full shall be combinational from registered state; an operation becomes visible the cycle after its clock edge.
REQ-016 PUSH when not full: din becomes the top entry and count increments by 1.
REQ-017 POP when not empty: the previous entry becomes the top and count decrements by 1; popped contents are not cleared.
REQ-018 REPLACE when not empty: din overwrites the top entry and count is unchanged.
REQ-019 REPLACE when empty: acts as a PUSH and sets unf.
REQ-020 POP when empty: no state change except that unf is set.
REQ-021 PUSH when full: behaviour is governed by REQ-028 and REQ-029; ovf is set in both cases.
REQ-022 NOP: no state change.
REQ-023 The top pointer shall wrap modulo DEPTH in both directions.
REQ-024 err_clr clears ovf and unf on the next edge; if a new error occurs in the same cycle, the set takes priority.

Reset
REQ-025 On rst high, immediately and independent of clk: count=0, top pointer=0, ovf=0, unf=0, hence empty=1, full=0, dout=0.
REQ-026 Array contents are not reset; they are not observable while empty.
REQ-027 A rst assertion in the middle of a sequence shall abort any pending operation; the first operation after release behaves as on an empty stack.

Configuration
REQ-028 Macro PC_STACK_WRAP_EN defined: a PUSH when full discards the oldest entry, din becomes the top, and count stays at DEPTH.
REQ-029 Macro PC_STACK_WRAP_EN undefined: a PUSH when full is ignored; contents, pointer and count are unchanged.

Verification
REQ-030 Reset, then 8 PUSHes of 0x101..0x108 with DEPTH=8 -> full=1, count=8, dout=0x108; then 8 POPs -> dout sequence 0x107..0x101, then 0, with empty=1.
REQ-031 POP on empty -> unf=1, count=0, dout=0; then err_clr for 1 cycle -> unf=0; err_clr together with another empty POP -> unf remains 1.
REQ-032 On a full stack holding 0x101..0x108, PUSH 0x1FF -> ovf=1; without the macro dout=0x108 and draining returns 0x108..0x101; with the macro dout=0x1FF and draining returns 0x1FF,0x108..0x102.
REQ-033 PUSH 0x055, PUSH 0x066, REPLACE 0x077 -> count=2, dout=0x077; POP -> dout=0x055; REPLACE on empty with 0x0AA -> count=1, dout=0x0AA, unf=1.
REQ-034 Assert rst asynchronously between edges after 3 PUSHes -> count=0, empty=1, dout=0 before the next edge; a subsequent POP sets unf.
REQ-035 Run 20 PUSH and 20 POP cycles with W=16 and DEPTH=4 and the macro defined -> the pointer wraps correctly and the last 4 pushed values pop in LIFO order.
